// File: rtl/data_memory_unit_pkg.sv
// Architecture widths, MMIO register map and STATUS layout for the data-memory unit.
// The backtick macros carry the architecture.vh constants shared with the core.
`ifndef ARCHITECTURE_VH
`define ARCHITECTURE_VH
`define ADDRESS_SIZE 16
`define DATA_SIZE 32
`define MMIO_FIFO_DATA 0
`define MMIO_STATUS 1
`define MMIO_CYCLES 2
`define STATUS_EMPTY_BIT 0
`define STATUS_FULL_BIT 1
`define STATUS_OVERFLOW_BIT 2
`define STATUS_COUNT_LSB 3
`endif

package data_memory_unit_pkg;

    typedef enum logic [1:0] {
        RegFifoData = 2'(`MMIO_FIFO_DATA),
        RegStatus   = 2'(`MMIO_STATUS),
        RegCycles   = 2'(`MMIO_CYCLES),
        RegReserved = 2'd3
    } mmio_reg_e;

    localparam int unsigned StatusEmptyBit    = `STATUS_EMPTY_BIT;
    localparam int unsigned StatusFullBit     = `STATUS_FULL_BIT;
    localparam int unsigned StatusOverflowBit = `STATUS_OVERFLOW_BIT;
    localparam int unsigned StatusCountLsb    = `STATUS_COUNT_LSB;

endpackage

// File: rtl/data_memory_unit_fifo_buffer.sv
// Parameterised synchronous FIFO with combinational head word (zero when empty).
// A push while full is accepted only if a pop frees the slot in the same cycle.
module fifo_buffer
    import data_memory_unit_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned WIDTH      = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic [WIDTH-1:0]      head
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FullCount = (DEPTH_LOG2 + 1)'(Depth);

    logic [WIDTH-1:0]      mem_q [Depth];
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FullCount);
    assign count   = count_q;
    assign head    = empty ? '0 : mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (DEPTH_LOG2)'(1);
        end
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + (DEPTH_LOG2)'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; head is masked by empty instead.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/data_memory_unit.sv
// Data-memory responder: word RAM plus MMIO output FIFO, STATUS and optional CYCLES counter.
// Define DMEM_CYCLE_COUNTER_EN to build the free-running cycle counter.
module data_memory_unit
    import data_memory_unit_pkg::*;
#(
    parameter int unsigned RAM_DEPTH_LOG2  = 10,
    parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     read,
    input  logic                     write,
    input  logic [`ADDRESS_SIZE-1:0] address,
    input  logic [`DATA_SIZE-1:0]    data_in,
    output logic [`DATA_SIZE-1:0]    data_out,
    output logic [`DATA_SIZE-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overflow
);

    localparam int unsigned AddrWidth = `ADDRESS_SIZE;
    localparam int unsigned DataWidth = `DATA_SIZE;
    localparam int unsigned RamDepth  = 2 ** RAM_DEPTH_LOG2;

    logic                      is_mmio;
    mmio_reg_e                 reg_sel;
    logic [RAM_DEPTH_LOG2-1:0] ram_index;
    logic                      unused_addr_bits;

    assign is_mmio   = address[AddrWidth-1];
    assign reg_sel   = mmio_reg_e'(address[1:0]);
    assign ram_index = address[RAM_DEPTH_LOG2-1:0];
    // Bits between the RAM index and the MMIO select only alias.
    assign unused_addr_bits = ^address[AddrWidth-2:RAM_DEPTH_LOG2];

    logic mmio_write, fifo_push, status_write;

    assign mmio_write   = write && is_mmio;
    assign fifo_push    = mmio_write && (reg_sel == RegFifoData);
    assign status_write = mmio_write && (reg_sel == RegStatus);

    // Output FIFO
    logic                     fifo_full, fifo_empty, fifo_pop;
    logic [FIFO_DEPTH_LOG2:0] fifo_count;

    assign out_valid = !fifo_empty;
    assign fifo_pop  = out_valid && out_ready;

    fifo_buffer #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
        .WIDTH      (DataWidth)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (data_in),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (out_data)
    );

    // Sticky overflow; a dropped push outranks a clear in the same cycle.
    logic overflow_q, overflow_d, overflow_set, overflow_clear;

    assign overflow_set   = fifo_push && fifo_full && !fifo_pop;
    assign overflow_clear = status_write && data_in[StatusOverflowBit];
    assign overflow       = overflow_q;

    always_comb begin
        overflow_d = overflow_q;
        if (overflow_set) begin
            overflow_d = 1'b1;
        end else if (overflow_clear) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    // Cycle counter
    logic [DataWidth-1:0] cycles_rdata;

`ifdef DMEM_CYCLE_COUNTER_EN
    logic                 cycles_write;
    logic [DataWidth-1:0] cycles_q, cycles_d;

    assign cycles_write = mmio_write && (reg_sel == RegCycles);
    assign cycles_rdata = cycles_q;

    always_comb begin
        cycles_d = cycles_q + (DataWidth)'(1);
        if (cycles_write) begin
            cycles_d = data_in;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end
`else
    assign cycles_rdata = '0;
`endif

    // Data RAM: contents survive reset.
    logic [DataWidth-1:0] ram_q [RamDepth];

    always_ff @(posedge clock) begin
        if (write && !is_mmio) begin
            ram_q[ram_index] <= data_in;
        end
    end

    // Combinational read path
    logic [DataWidth-1:0] status_word, mmio_rdata;

    always_comb begin
        status_word                    = '0;
        status_word[StatusEmptyBit]    = fifo_empty;
        status_word[StatusFullBit]     = fifo_full;
        status_word[StatusOverflowBit] = overflow_q;
        status_word[StatusCountLsb +: FIFO_DEPTH_LOG2 + 1] = fifo_count;
    end

    always_comb begin
        mmio_rdata = '0;
        unique case (reg_sel)
            RegFifoData: mmio_rdata = '0;
            RegStatus:   mmio_rdata = status_word;
            RegCycles:   mmio_rdata = cycles_rdata;
            RegReserved: mmio_rdata = '0;
            default:     mmio_rdata = '0;
        endcase
    end

    always_comb begin
        data_out = '0;
        if (read) begin
            data_out = is_mmio ? mmio_rdata : ram_q[ram_index];
        end
    end

endmodule

// File: tb/tb_data_memory_unit.sv
// Bench for data_memory_unit: directed scenarios plus randomized traffic against a
// queue/array reference model checked every cycle on the falling clock edge.
module tb_data_memory_unit;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int RL = 10;
    localparam int FD = 8;

    logic          clock     = 1'b0;
    logic          reset     = 1'b1;
    logic          read      = 1'b0;
    logic          write     = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] address   = '0;
    logic [DW-1:0] data_in   = '0;
    logic [DW-1:0] data_out, out_data;
    logic          out_valid, overflow;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    logic [DW-1:0] ram_m [1024];
    bit            ram_ok [1024];
    logic [DW-1:0] fifo_m [$];
    bit            ovf_m = 1'b0;
    logic [DW-1:0] cyc_m = '0;

    always #5 clock = ~clock;

    data_memory_unit #(
        .RAM_DEPTH_LOG2  (RL),
        .FIFO_DEPTH_LOG2 (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .read      (read),
        .write     (write),
        .address   (address),
        .data_in   (data_in),
        .data_out  (data_out),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] status_m();
        logic [DW-1:0] s;
        s = DW'(fifo_m.size()) * 8;
        if (ovf_m) s = s + 4;
        if (fifo_m.size() == FD) s = s + 2;
        if (fifo_m.size() == 0) s = s + 1;
        return s;
    endfunction

    // Model update at each active edge, flushed by the asynchronous reset.
    always @(posedge clock or negedge reset) begin
        bit mmio, was_full, pop, push, clr, drop;
        int sel;
        if (!reset) begin
            fifo_m.delete();
            ovf_m = 1'b0;
            cyc_m = '0;
        end else begin
            mmio     = address[AW-1];
            sel      = int'(address[1:0]);
            was_full = (fifo_m.size() == FD);
            pop      = (fifo_m.size() != 0) && out_ready;
            push     = write && mmio && (sel == 0);
            clr      = write && mmio && (sel == 1) && data_in[2];
            drop     = push && was_full && !pop;
            if (write && !mmio) begin
                ram_m[address[RL-1:0]]  = data_in;
                ram_ok[address[RL-1:0]] = 1'b1;
            end
            if (pop) void'(fifo_m.pop_front());
            if (push && !drop) fifo_m.push_back(data_in);
            if (drop) ovf_m = 1'b1;
            else if (clr) ovf_m = 1'b0;
            cyc_m = (write && mmio && sel == 2) ? data_in : cyc_m + 1;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clock) begin
        logic [DW-1:0] exp;
        bit known;
        check("out_valid", DW'(out_valid), DW'(fifo_m.size() != 0));
        check("out_data", out_data, (fifo_m.size() != 0) ? fifo_m[0] : '0);
        check("overflow", DW'(overflow), DW'(ovf_m));
        known = 1'b1;
        exp   = '0;
        if (read) begin
            if (!address[AW-1]) begin
                known = ram_ok[address[RL-1:0]];
                exp   = ram_m[address[RL-1:0]];
            end else begin
                case (address[1:0])
                    2'd1: exp = status_m();
                    2'd2: begin
`ifdef DMEM_CYCLE_COUNTER_EN
                        exp = cyc_m;
`else
                        exp = '0;
`endif
                    end
                    default: exp = '0;
                endcase
            end
        end
        if (known) check("data_out", data_out, exp);
    end

    task automatic step(input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic rdy);
        @(posedge clock);
        #1;
        read      = rd;
        write     = wr;
        address   = a;
        data_in   = d;
        out_ready = rdy;
        #2;
    endtask

    initial begin
        logic [AW-1:0] a;
        int pct;
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        #3;
        check("rst_out_valid", DW'(out_valid), '0);
        check("rst_out_data", out_data, '0);
        check("rst_overflow", DW'(overflow), '0);
        @(posedge clock);
        #1 reset = 1'b1;

        // RAM write/read, aliasing, read-before-write
        step(1'b0, 1'b1, 16'h0004, 32'hA5, 1'b0);
        step(1'b1, 1'b0, 16'h0004, '0, 1'b0);
        check("ram_read", data_out, 32'hA5);
        step(1'b1, 1'b0, 16'h0404, '0, 1'b0);
        check("ram_alias", data_out, 32'hA5);
        step(1'b1, 1'b1, 16'h0004, 32'h5A, 1'b0);
        check("ram_pre_write", data_out, 32'hA5);
        step(1'b1, 1'b0, 16'h0004, '0, 1'b0);
        check("ram_post_write", data_out, 32'h5A);

        // Fill, overflow, drain
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 16'h8000, DW'(i), 1'b0);
        step(1'b1, 1'b0, 16'h8001, '0, 1'b0);
        check("status_full", data_out, 32'h42);
        step(1'b0, 1'b1, 16'h8000, 32'd9, 1'b0);
        step(1'b1, 1'b0, 16'h8001, '0, 1'b0);
        check("status_overflow", data_out, 32'h46);
        check("overflow_pin", DW'(overflow), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b0, '0, '0, 1'b1);
            check("drain_order", out_data, DW'(i));
        end
        step(1'b0, 1'b0, '0, '0, 1'b0);
        check("drained_valid", DW'(out_valid), '0);
        step(1'b0, 1'b1, 16'h8001, 32'd4, 1'b0);
        step(1'b1, 1'b0, 16'h8001, '0, 1'b0);
        check("overflow_clear", data_out, 32'h01);

        // Push and pop together while full
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 16'h8000, DW'(i), 1'b0);
        step(1'b0, 1'b1, 16'h8000, 32'd9, 1'b1);
        step(1'b1, 1'b0, 16'h8001, '0, 1'b0);
        check("full_push_pop_status", data_out, 32'h42);
        for (int i = 2; i <= 9; i++) begin
            step(1'b0, 1'b0, '0, '0, 1'b1);
            check("drain_after_swap", out_data, DW'(i));
        end

        // Asynchronous reset flushes the FIFO but not the RAM
        step(1'b0, 1'b1, 16'h0007, 32'h1234, 1'b0);
        for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 16'h8000, DW'(i), 1'b0);
        step(1'b1, 1'b0, 16'h8001, '0, 1'b0);
        check("status_three", data_out, 32'h18);
        reset = 1'b0;
        #1;
        check("rst_flush_valid", DW'(out_valid), '0);
        check("rst_flush_status", data_out, 32'h01);
        @(posedge clock);
        #1 reset = 1'b1;
        step(1'b1, 1'b0, 16'h0007, '0, 1'b0);
        check("ram_survives_reset", data_out, 32'h1234);

        // CYCLES register
        step(1'b0, 1'b1, 16'h8002, 32'hFFFF_FFFE, 1'b0);
`ifdef DMEM_CYCLE_COUNTER_EN
        step(1'b1, 1'b0, 16'h8002, '0, 1'b0);
        check("cycles_loaded", data_out, 32'hFFFF_FFFE);
        step(1'b1, 1'b0, 16'h8002, '0, 1'b0);
        check("cycles_max", data_out, 32'hFFFF_FFFF);
        step(1'b1, 1'b0, 16'h8002, '0, 1'b0);
        check("cycles_wrap", data_out, 32'h0);
`else
        step(1'b1, 1'b0, 16'h8002, '0, 1'b0);
        check("cycles_absent", data_out, 32'h0);
`endif
        step(1'b1, 1'b0, 16'h8003, '0, 1'b0);
        check("reserved_reads_zero", data_out, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            pct = ((n / 500) % 2 == 1) ? 80 : 15;
            if ($urandom_range(0, 99) < 50)
                a = {1'b1, 13'($urandom), 2'($urandom)};
            else
                a = {1'b0, 5'($urandom), 6'b0, 4'($urandom)};
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
                 1'($urandom_range(0, 99) < pct));
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b0;
                #1;
                check("rand_rst_valid", DW'(out_valid), '0);
                @(posedge clock);
                #1 reset = 1'b1;
            end
        end

        @(posedge clock);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
